// File: rtl/quantum_scheduler_pkg.sv
// Shared types and constants for the quantum preemption scheduler.
// Optional I/O-cycle exemption: QUANTUM_SCHEDULER_IO_EXEMPT_EN.
package quantum_scheduler_pkg;

  localparam int unsigned QW_DEFAULT = 16;
  localparam logic [15:0] DEFAULT_QUANTUM_C = 16'd1000;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PENDING = 2'b10
  } state_t;

endpackage

// File: rtl/quantum_counter.sv
// Loadable down-counter that saturates at zero.
// at_one flags the final counted step of a quantum.
module quantum_counter #(
  parameter int unsigned W = 16,
  parameter logic [W-1:0] RESET_VALUE = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         at_one
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign at_one = (count == W'(1));

endmodule

// File: rtl/quantum_scheduler.sv
// Preemption scheduler: counts user-mode cycles, raises interruption
// on quantum expiry. Macro QUANTUM_SCHEDULER_IO_EXEMPT_EN skips I/O cycles.
module quantum_scheduler
  import quantum_scheduler_pkg::*;
#(
  parameter int unsigned QUANTUM_WIDTH = QW_DEFAULT,
  parameter logic [QUANTUM_WIDTH-1:0] DEFAULT_QUANTUM =
    QUANTUM_WIDTH'(DEFAULT_QUANTUM_C)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     is_os,
  input  logic                     is_bios,
  input  logic                     is_io,
  input  logic                     quantum_load,
  input  logic [QUANTUM_WIDTH-1:0] quantum_value,
  input  logic                     interrupt_ack,
  output logic                     interruption,
  output logic [QUANTUM_WIDTH-1:0] remaining
);

  state_t state;
  state_t state_next;

  logic [QUANTUM_WIDTH-1:0] q_reg;
  logic [QUANTUM_WIDTH-1:0] q_next;
  logic                     supervisor;
  logic                     q_write;
  logic                     step;
  logic                     cnt_load;
  logic                     cnt_dec;
  logic                     at_one;

  assign supervisor = is_os | is_bios;
  assign q_write    = quantum_load & supervisor;
  assign q_next     = q_write ? quantum_value : q_reg;

`ifdef QUANTUM_SCHEDULER_IO_EXEMPT_EN
  assign step = enable & ~is_io;
`else
  logic unused_io;
  assign unused_io = is_io;
  assign step = enable;
`endif

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_load = 1'b1;
        if (!supervisor && q_reg != '0) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // A trap back to supervisor wins over the final decrement.
        if (supervisor) begin
          state_next = IDLE;
          cnt_load   = 1'b1;
        end else if (step) begin
          cnt_dec = 1'b1;
          if (at_one) begin
            state_next = PENDING;
          end
        end
      end
      PENDING: begin
        if (interrupt_ack) begin
          state_next = IDLE;
          cnt_load   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_load   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      interruption <= 1'b0;
      q_reg        <= DEFAULT_QUANTUM;
    end else begin
      state        <= state_next;
      interruption <= (state_next == PENDING);
      if (q_write) begin
        q_reg <= quantum_value;
      end
    end
  end

  quantum_counter #(
    .W           (QUANTUM_WIDTH),
    .RESET_VALUE (DEFAULT_QUANTUM)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (q_next),
    .dec        (cnt_dec),
    .count      (remaining),
    .at_one     (at_one)
  );

endmodule

// File: tb/tb_quantum_scheduler.sv
// Testbench for quantum_scheduler: vector table with scoreboard queue
// plus hand-written reset-in-PENDING sequence.
module tb_quantum_scheduler;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        is_os;
  logic        is_bios;
  logic        is_io;
  logic        quantum_load;
  logic [15:0] quantum_value;
  logic        interrupt_ack;
  logic        interruption;
  logic [15:0] remaining;

  int checks;
  int failures;

  typedef struct {
    logic        os;
    logic        en;
    logic        io;
    logic        ld;
    logic [15:0] val;
    logic        ack;
    logic        ei;
    logic [15:0] er;
  } vec_t;

  typedef struct {
    logic        ei;
    logic [15:0] er;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

`ifdef QUANTUM_SCHEDULER_IO_EXEMPT_EN
  localparam bit EX = 1'b1;
`else
  localparam bit EX = 1'b0;
`endif

  quantum_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .is_os         (is_os),
    .is_bios       (is_bios),
    .is_io         (is_io),
    .quantum_load  (quantum_load),
    .quantum_value (quantum_value),
    .interrupt_ack (interrupt_ack),
    .interruption  (interruption),
    .remaining     (remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(
    input logic os, input logic en, input logic io,
    input logic ld, input logic [15:0] val, input logic ack,
    input logic ei, input logic [15:0] er);
    vec_t v;
    v.os = os; v.en = en; v.io = io; v.ld = ld;
    v.val = val; v.ack = ack; v.ei = ei; v.er = er;
    return v;
  endfunction

  task automatic check(input string name,
                       input logic ai, input logic [15:0] ar,
                       input logic ei, input logic [15:0] er);
    checks++;
    if (ai !== ei || ar !== er) begin
      failures++;
      $display("FAIL %s: got int=%b rem=%0d, want int=%b rem=%0d",
               name, ai, ar, ei, er);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clock);
    is_os         = v.os;
    enable        = v.en;
    is_io         = v.io;
    quantum_load  = v.ld;
    quantum_value = v.val;
    interrupt_ack = v.ack;
    sbq.push_back('{ei: v.ei, er: v.er});
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    check($sformatf("vec%0d", idx), interruption, remaining, e.ei, e.er);
  endtask

  initial begin
    bit hit;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    enable = 1'b1;
    is_os = 1'b1;
    is_bios = 1'b0;
    is_io = 1'b0;
    quantum_load = 1'b0;
    quantum_value = '0;
    interrupt_ack = 1'b0;

    // os en io ld val ack | int rem
    vecs.push_back(mk(1, 1, 0, 1, 5, 0, 0, 5));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 5));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 5));
    // enable toggling
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 5));
    // ack outside PENDING
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 5));
    // supervisor on final decrement
    vecs.push_back(mk(1, 1, 0, 1, 3, 0, 0, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3));
    // user-mode load of 7 ignored
    vecs.push_back(mk(0, 0, 0, 1, 7, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 7, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3));
    // zero quantum disables preemption
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 4, 0, 0, 4));
    // I/O cycles mid-run
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, EX ? 16'd4 : 16'd3));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, EX ? 16'd4 : 16'd2));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, EX ? 16'd4 : 16'd1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, EX ? 1'b0 : 1'b1, EX ? 16'd3 : 16'd0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, EX ? 1'b0 : 1'b1, EX ? 16'd2 : 16'd0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, EX ? 1'b0 : 1'b1, EX ? 16'd1 : 16'd0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 4));

    #12;
    check("reset_low", interruption, remaining, 1'b0, 16'd1000);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_state", interruption, remaining, 1'b0, 16'd1000);

    foreach (vecs[i]) apply(vecs[i], i);

    // drive into PENDING with quantum 4, then reset asynchronously
    @(negedge clock);
    is_os = 1'b0;
    enable = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(posedge clock);
      #1;
      if (interruption === 1'b1) hit = 1'b1;
    end
    check("reach_pending", interruption, remaining, 1'b1, 16'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", interruption, remaining, 1'b0, 16'd1000);
    @(negedge clock);
    is_os = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("post_reset_q", interruption, remaining, 1'b0, 16'd1000);

    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: %0d entries left, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
